// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types for the SubBytes stage.
package aes_pkg;
    localparam int AES_SBOX_WIDTH = 8;
    localparam int AES_SBOX_DEPTH = 256;
    localparam int AES_DATA_WIDTH = 128;
    localparam int AES_N_LANES    = AES_DATA_WIDTH / AES_SBOX_WIDTH;

    typedef logic [AES_SBOX_WIDTH-1:0] aes_byte_t;
endpackage

// File: rtl/subbytes_sbox_mem.sv
// S-box table: register array with one synchronous write port and N_RD
// combinational read ports (one per state lane); async reset clears every entry.
module subbytes_sbox_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 256,
    parameter int N_RD  = 16,
    parameter int AW    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [N_RD*W-1:0] i_raddr,
    output logic [N_RD*W-1:0] o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Lane address width equals the entry width, so every byte value indexes the table.
    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        assign o_rdata[g*W +: W] = r_mem[i_raddr[g*W +: W]];
    end
endmodule

// File: rtl/subbytes.sv
// AES SubBytes with a runtime-loaded S-box: table streams in one byte per cycle,
// then each accepted state is substituted lane-parallel with 1-cycle latency.
module subbytes
    import aes_pkg::*;
#(
    parameter int SBOX_WIDTH = AES_SBOX_WIDTH,
    parameter int SBOX_DEPTH = AES_SBOX_DEPTH,
    parameter int DATA_WIDTH = AES_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sbox_valid,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] out
);
    localparam int N_LANES = DATA_WIDTH / SBOX_WIDTH;
    localparam int AW      = $clog2(SBOX_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SBOX_DEPTH - 1);

    logic [AW-1:0]         r_wptr;
    logic                  r_sbox_ready;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  w_load;
    logic                  w_lookup;
    logic [DATA_WIDTH-1:0] w_sub;

    // Once the table is full it is read-only; lookups need the flag from a prior cycle.
    assign w_load   = sbox_valid && !r_sbox_ready;
    assign w_lookup = tvalid && r_sbox_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr       <= '0;
            r_sbox_ready <= 1'b0;
        end else if (w_load) begin
            if (r_wptr == LAST_ADDR) begin
                r_sbox_ready <= 1'b1;
            end else begin
                r_wptr <= r_wptr + 1'b1;
            end
        end
    end

    subbytes_sbox_mem #(
        .W     (SBOX_WIDTH),
        .DEPTH (SBOX_DEPTH),
        .N_RD  (N_LANES),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_we    (w_load),
        .i_waddr (r_wptr),
        .i_wdata (sbox_out),
        .i_raddr (in),
        .o_rdata (w_sub)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_valid <= w_lookup;
            if (w_lookup) begin
                r_out <= w_sub;
            end
        end
    end

    assign valid = r_valid;
    assign out   = r_out;
endmodule

// File: tb/tb_subbytes.sv
// Randomized bench for subbytes: a table/counter reference model predicts valid
// and out every cycle; expected results travel through a queue.
module tb_subbytes;
    import aes_pkg::*;

    localparam int W = 128;

    logic         clk;
    logic         reset_n;
    logic         sbox_valid;
    logic [7:0]   sbox_out;
    logic         tvalid;
    logic [W-1:0] din;
    logic         valid;
    logic [W-1:0] dout;

    int n_vec;
    int n_err;

    // Reference model state
    aes_byte_t    ref_tbl [256];
    int           ref_cnt;
    bit           ref_ready;
    bit           exp_valid;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_q[$];

    subbytes dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sbox_valid (sbox_valid),
        .sbox_out   (sbox_out),
        .tvalid     (tvalid),
        .in         (din),
        .valid      (valid),
        .out        (dout)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] substitute(input logic [W-1:0] s);
        logic [W-1:0] r;
        for (int i = 0; i < W / 8; i++) begin
            r[8*i +: 8] = ref_tbl[s[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_tbl[i] = '0;
        ref_cnt   = 0;
        ref_ready = 1'b0;
        exp_valid = 1'b0;
        exp_out   = '0;
        exp_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        reset_n    = 1'b0;
        sbox_valid = 1'b0;
        tvalid     = 1'b0;
        model_reset();
        #2;
        check_val("reset_valid", {127'b0, valid}, '0);
        check_val("reset_out", dout, '0);
        repeat (cycles) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock: drive inputs, advance the model, check outputs after the edge.
    task automatic drive_cycle(input bit sv, input logic [7:0] sb, input bit tv, input logic [W-1:0] d);
        sbox_valid = sv;
        sbox_out   = sb;
        tvalid     = tv;
        din        = d;
        exp_valid  = tv && ref_ready;
        if (exp_valid) exp_q.push_back(substitute(d));
        if (sv && !ref_ready) begin
            ref_tbl[ref_cnt] = sb;
            ref_cnt++;
            if (ref_cnt == 256) ref_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check_val("valid", {127'b0, valid}, {127'b0, exp_valid});
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL queue: got empty expected-result queue, required one entry");
            end else begin
                exp_out = exp_q.pop_front();
            end
        end
        check_val("out", dout, exp_out);
    endtask

    function automatic logic [W-1:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_reversed(input int n_bytes, input bit gaps, input bit poke);
        int i;
        i = 0;
        while (i < n_bytes) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive_cycle(1'b0, 8'($urandom()), poke && $urandom_range(0, 1) == 1, rand_state());
            end else begin
                drive_cycle(1'b1, 8'(255 - i), poke, rand_state());
                i++;
            end
        end
    endtask

    task automatic load_identity();
        int i;
        i = 0;
        while (i < 256) begin
            if ($urandom_range(0, 2) == 0) begin
                drive_cycle(1'b0, 8'($urandom()), $urandom_range(0, 1) == 1, rand_state());
            end else begin
                drive_cycle(1'b1, 8'(i), $urandom_range(0, 1) == 1, rand_state());
                i++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 8'h00, 1'b0, '0);
    endtask

    logic [W-1:0] known_in;
    logic [W-1:0] known_out;
    logic [W-1:0] st;

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        sbox_valid = 1'b0;
        sbox_out   = '0;
        tvalid     = 1'b0;
        din        = '0;
        known_in   = 128'h0123456789ABCDEFFEDCBA9876543210;
        known_out  = 128'hFEDCBA98765432100123456789ABCDEF;

        // Reversed table with tvalid held high throughout load (incl. last byte).
        do_reset(3);
        idle(2);
        load_reversed(256, 1'b0, 1'b1);
        idle(2);
        drive_cycle(1'b0, 8'h00, 1'b1, known_in);
        check_val("known_vector", dout, known_out);
        idle(3);
        check_val("known_hold", dout, known_out);

        // Identity table with gaps; random lookups with random spacing.
        do_reset(2);
        load_identity();
        for (int k = 0; k < 60; k++) begin
            st = rand_state();
            drive_cycle(1'b0, 8'h00, $urandom_range(0, 1) == 1, st);
        end
        // Back-to-back triple, then hold.
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 8'h00, 1'b1, rand_state());
        idle(4);
        // Extra table bytes after the table is full are ignored.
        for (int k = 0; k < 40; k++) begin
            drive_cycle(1'b1, 8'($urandom()), $urandom_range(0, 1) == 1, rand_state());
        end
        st = rand_state();
        drive_cycle(1'b0, 8'h00, 1'b1, st);
        check_val("identity_after_extra", dout, st);

        // Reset mid-load, attempted lookups dropped, then full reload.
        do_reset(2);
        load_reversed(100, 1'b1, 1'b0);
        do_reset(2);
        load_reversed(256, 1'b1, 1'b1);
        idle(1);
        drive_cycle(1'b0, 8'h00, 1'b1, known_in);
        check_val("reload_known_vector", dout, known_out);
        for (int k = 0; k < 30; k++) drive_cycle(1'b0, 8'h00, $urandom_range(0, 1) == 1, rand_state());
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
